tie_wire_arbiter: RTL and testbench
===================================

TIE_WIRE_ARBITER -- requirements
Module: tie_wire_arbiter

Interface
REQ-001 Parameter WIDTH, default 50, SHALL set the TIE control/status wire width in bits.
REQ-002 Parameter HOLD_CYCLES, default 4, range 1..255, SHALL set the number of cycles a new tie_control value is held stable before another update.
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 BReset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  SHALL flag that requester 0/1 offers a new status word.
REQ-006 req0_data / req1_data  input  WIDTH  SHALL carry requester 0/1 TIE_status words.
REQ-007 req0_ready / req1_ready  output  1  SHALL accept the offered word; a transfer occurs when valid and ready are both high at a rising edge.
REQ-008 tie_control  output  WIDTH  SHALL be the registered word driven to the consumer core's TIE_control.
REQ-009 tie_update  output  1  SHALL pulse high for exactly one cycle when tie_control takes a new value.
REQ-010 grant_id  output  1  SHALL hold the index of the requester whose word is on tie_control.
REQ-011 busy  output  1  SHALL be high while in state HOLD.

Function
REQ-012 The FSM SHALL have two states: IDLE and HOLD.
REQ-013 In IDLE, ready SHALL be combinational: only one valid high -> that requester's ready high; both high -> requester selected by the round-robin pointer; neither -> both ready low.
REQ-014 In HOLD, both ready outputs SHALL be low; valid and data inputs SHALL be ignored.
REQ-015 Requesters SHALL keep valid and data stable until accepted; the block does not check this.
REQ-016 On a transfer at edge t: tie_control <= accepted data, grant_id <= requester index, tie_update = 1 for the cycle after t, state -> HOLD, hold counter <= HOLD_CYCLES-1.
REQ-017 In HOLD the counter SHALL decrement each cycle; at counter 0 the next state SHALL be IDLE; minimum spacing between tie_update pulses SHALL be HOLD_CYCLES+1 cycles.
REQ-018 The round-robin pointer SHALL point to the non-granted requester after every transfer; it SHALL be unchanged when no transfer occurs.
REQ-019 tie_control and grant_id SHALL change only on a transfer; they SHALL remain stable through HOLD and IDLE otherwise.
REQ-020 A requester that keeps valid high SHALL be granted at most once per two grants while the other requester is also valid.

Reset
REQ-021 While BReset is high, outputs SHALL be: state IDLE, tie_control 0, tie_update 0, grant_id 0, busy 0, counter 0, pointer on requester 0.
REQ-022 Reset asserted mid-HOLD SHALL abort the hold immediately; the first transfer after deassertion SHALL follow the IDLE rules.
REQ-023 ready outputs SHALL be low while BReset is high.

Configuration
REQ-024 With TIE_ARB_CHANGE_FILTER_EN defined, a transfer whose data equals the current tie_control SHALL be accepted and rotate the pointer, but SHALL NOT update grant_id, pulse tie_update or enter HOLD; the FSM stays in IDLE.
REQ-025 Without TIE_ARB_CHANGE_FILTER_EN, every transfer SHALL follow REQ-016 regardless of data value.

Verification
REQ-026 Reset release, req0_valid=1, data=0x3_FFFF_0000_1234 -> req0_ready=1 in the same cycle; next cycle tie_control=0x3_FFFF_0000_1234, tie_update=1, grant_id=0, busy=1.
REQ-027 HOLD_CYCLES=4, both valid continuously -> grants alternate 0,1,0,1; tie_update pulses exactly every 5 cycles; ready stays low during each 4-cycle HOLD.
REQ-028 Transfer from req1, then req1_valid=1 during HOLD with a new word -> req1_ready stays 0 for 4 cycles and the word is accepted on the first IDLE cycle.
REQ-029 BReset pulsed on the 2nd HOLD cycle -> tie_control=0, busy=0, pointer=0 immediately; after release a pending req1 is granted next cycle.
REQ-030 TIE_ARB_CHANGE_FILTER_EN defined, req0 resends the current tie_control value -> req0_ready=1, no tie_update, busy=0; with the macro undefined -> tie_update=1 and busy=1 for 4 cycles.

Source files
------------

// File: rtl/tie_wire_arbiter_if.sv
// Handshake and output bundle for tie_wire_arbiter.
// master: requester/consumer side, slave: the arbiter itself.
interface tie_wire_arbiter_if #(
    parameter int WIDTH = 50
);
    logic             req0_valid;
    logic             req1_valid;
    logic [WIDTH-1:0] req0_data;
    logic [WIDTH-1:0] req1_data;
    logic             req0_ready;
    logic             req1_ready;
    logic [WIDTH-1:0] tie_control;
    logic             tie_update;
    logic             grant_id;
    logic             busy;

    modport master (
        output req0_valid, req1_valid, req0_data, req1_data,
        input  req0_ready, req1_ready, tie_control, tie_update, grant_id, busy
    );

    modport slave (
        input  req0_valid, req1_valid, req0_data, req1_data,
        output req0_ready, req1_ready, tie_control, tie_update, grant_id, busy
    );
endinterface

// File: rtl/tie_wire_arbiter.sv
// Two-requester round-robin arbiter driving a registered TIE_control word.
// A new word is held for HOLD_CYCLES cycles before the next one is accepted.
// Optional macro TIE_ARB_CHANGE_FILTER_EN: a transfer that carries the value
// already on tie_control is consumed silently (pointer rotates, no update).
//
// state | meaning
// IDLE  | ready offered to a valid requester, waiting for a transfer
// HOLD  | new word on tie_control, counting down, ready held low
module tie_wire_arbiter #(
    parameter int WIDTH       = 50,
    parameter int HOLD_CYCLES = 4
) (
    input logic               CLK,
    input logic               BReset,
    tie_wire_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [7:0] HOLD_CNT_INIT = 8'(HOLD_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       hold_cnt_q;
    logic             rr_ptr_q;
    logic [WIDTH-1:0] tie_control_q;
    logic             tie_update_q;
    logic             grant_id_q;
    logic             ready0;
    logic             ready1;
    logic             xfer;
    logic             xfer_new;
    logic             xfer_id;
    logic [WIDTH-1:0] xfer_data;

    assign xfer      = ready0 | ready1;
    assign xfer_id   = ready1;
    assign xfer_data = ready1 ? bus.req1_data : bus.req0_data;

`ifdef TIE_ARB_CHANGE_FILTER_EN
    assign xfer_new = xfer && (xfer_data != tie_control_q);
`else
    assign xfer_new = xfer;
`endif

    // State register.
    always_ff @(posedge CLK or posedge BReset) begin
        if (BReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a word that changes tie_control starts a hold; hold ends at count 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer_new) state_d = HOLD;
            HOLD:    if (hold_cnt_q == 8'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready outputs: combinational grant in IDLE, round-robin pointer breaks ties.
    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (state_q == IDLE && !BReset) begin
            if (bus.req0_valid && bus.req1_valid) begin
                ready0 = ~rr_ptr_q;
                ready1 = rr_ptr_q;
            end else begin
                ready0 = bus.req0_valid;
                ready1 = bus.req1_valid;
            end
        end
    end

    // Datapath: capture accepted word, run hold counter, rotate pointer.
    always_ff @(posedge CLK or posedge BReset) begin
        if (BReset) begin
            tie_control_q <= '0;
            tie_update_q  <= 1'b0;
            grant_id_q    <= 1'b0;
            hold_cnt_q    <= 8'd0;
            rr_ptr_q      <= 1'b0;
        end else begin
            tie_update_q <= xfer_new;
            if (xfer) begin
                rr_ptr_q <= ~xfer_id;
            end
            if (xfer_new) begin
                tie_control_q <= xfer_data;
                grant_id_q    <= xfer_id;
                hold_cnt_q    <= HOLD_CNT_INIT;
            end else if (state_q == HOLD && hold_cnt_q != 8'd0) begin
                hold_cnt_q <= hold_cnt_q - 8'd1;
            end
        end
    end

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.tie_control = tie_control_q;
    assign bus.tie_update  = tie_update_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.busy        = (state_q == HOLD);
endmodule

// File: tb/tb_tie_wire_arbiter.sv
// Self-checking bench for tie_wire_arbiter: vector table, corner sequences,
// and a randomized run against a behavioural model.
module tb_tie_wire_arbiter;
    localparam int WIDTH = 50;
    localparam int HOLD  = 4;
    typedef logic [WIDTH-1:0] word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    tie_wire_arbiter_if #(.WIDTH(WIDTH)) bus_if ();

    tie_wire_arbiter #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
        .CLK   (clk),
        .BReset(rst),
        .bus   (bus_if.slave)
    );

    typedef struct {
        logic  v0, v1;
        word_t d0, d1;
        logic  r0, r1;
        word_t ctl;
        logic  upd, gid, busy;
    } vec_t;

    localparam word_t D0 = 50'h3_FFFF_0000_1234;
    localparam word_t D1 = 50'h1_2345_6789_ABCD;
    localparam word_t D2 = 50'h2_0F0F_A5A5_0001;
    localparam word_t DA = 50'h0_AAAA_5555_0003;
    localparam word_t DB = 50'h1_BBBB_0000_7777;
    localparam word_t DC = 50'h2_CCCC_1111_0042;

    task automatic chk_w(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0b expected %0b", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic v0, input logic v1, input word_t d0, input word_t d1);
        bus_if.req0_valid = v0;
        bus_if.req1_valid = v1;
        bus_if.req0_data  = d0;
        bus_if.req1_data  = d1;
    endtask

    task automatic chk_out(input string tag, input word_t ctl, input logic upd,
                           input logic gid, input logic busy);
        chk_w({tag, " tie_control"}, bus_if.tie_control, ctl);
        chk_b({tag, " tie_update"}, bus_if.tie_update, upd);
        chk_b({tag, " grant_id"}, bus_if.grant_id, gid);
        chk_b({tag, " busy"}, bus_if.busy, busy);
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk_b({tag, " req0_ready"}, bus_if.req0_ready, r0);
        chk_b({tag, " req1_ready"}, bus_if.req1_ready, r1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic word_t rand_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[WIDTH-1:0];
    endfunction

    // Grant req0, reset on the 2nd hold cycle, release with the given requests.
    task automatic reset_mid_hold(input string tag, input logic v0, input logic v1,
                                  input logic er0, input logic er1);
        do_reset();
        @(negedge clk);
        drive(1'b1, 1'b0, DA, '0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        chk_b({tag, " busy before reset"}, bus_if.busy, 1'b1);
        #2;
        rst = 1'b1;
        drive(v0, v1, DC, DC);
        #1;
        chk_out({tag, " in reset"}, '0, 1'b0, 1'b0, 1'b0);
        chk_rdy({tag, " in reset"}, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_rdy({tag, " after release"}, er0, er1);
        @(posedge clk);
        #1;
        chk_out({tag, " first grant"}, DC, 1'b1, er1, 1'b1);
    endtask

    vec_t tbl[12];

    // Behavioural model state
    word_t m_ctl;
    logic  m_gid, m_upd;
    int    m_hold_left, m_ptr;

    initial begin
        tbl[0] = '{1, 0, D0, '0, 1, 0, D0, 1, 0, 1};
        for (int i = 1; i <= 4; i++) tbl[i] = '{1, 1, D2, D1, 0, 0, D0, 0, 0, (i < 4)};
        tbl[5] = '{1, 1, D2, D1, 0, 1, D1, 1, 1, 1};
        for (int i = 6; i <= 9; i++) tbl[i] = '{1, 1, D2, D1, 0, 0, D1, 0, 1, (i < 9)};
        tbl[10] = '{1, 1, D2, D1, 1, 0, D2, 1, 0, 1};
        tbl[11] = '{0, 0, '0, '0, 0, 0, D2, 0, 0, 1};

        // Reset state, with requests pending to show ready is held low.
        drive(1'b1, 1'b1, D0, D1);
        #12;
        chk_out("reset", '0, 1'b0, 1'b0, 1'b0);
        chk_rdy("reset", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, '0, '0);

        // Vector table: first transfer, alternation, 5-cycle update spacing.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(tbl[i].v0, tbl[i].v1, tbl[i].d0, tbl[i].d1);
            #1;
            chk_rdy($sformatf("vec%0d", i), tbl[i].r0, tbl[i].r1);
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), tbl[i].ctl, tbl[i].upd, tbl[i].gid, tbl[i].busy);
        end

        // req1 re-offers during hold; accepted on the first idle cycle.
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, '0, DA);
        #1;
        chk_rdy("hold_wait grant", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk_out("hold_wait first", DA, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, '0, DB);
            #1;
            chk_rdy($sformatf("hold_wait c%0d", i), 1'b0, 1'b0);
        end
        @(negedge clk);
        #1;
        chk_rdy("hold_wait idle", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk_out("hold_wait second", DB, 1'b1, 1'b1, 1'b1);

        // Reset mid-hold: pointer back on req0, then pending req1 alone.
        reset_mid_hold("rst_ptr", 1'b1, 1'b1, 1'b1, 1'b0);
        reset_mid_hold("rst_req1", 1'b0, 1'b1, 1'b0, 1'b1);

        // req0 resends the value already on tie_control.
        do_reset();
        @(negedge clk);
        drive(1'b1, 1'b0, D0, '0);
        @(posedge clk);
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, '0, '0);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, D0, '0);
        #1;
        chk_rdy("resend", 1'b1, 1'b0);
        @(posedge clk);
        #1;
`ifdef TIE_ARB_CHANGE_FILTER_EN
        chk_out("resend filtered", D0, 1'b0, 1'b0, 1'b0);
`else
        chk_out("resend", D0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < HOLD; i++) begin
            @(posedge clk);
            #1;
            chk_b($sformatf("resend busy c%0d", i), bus_if.busy, 1'b1);
        end
        @(posedge clk);
        #1;
        chk_b("resend busy end", bus_if.busy, 1'b0);
`endif

        // Randomized run against the behavioural model.
        do_reset();
        begin
            logic  cv0, cv1, acc0, acc1, er0, er1;
            word_t cd0, cd1, dsel;
            int    sel;
            bit    is_new;
            cv0 = 0; cv1 = 0; acc0 = 0; acc1 = 0;
            cd0 = '0; cd1 = '0;
            m_ctl = '0; m_gid = 0; m_upd = 0; m_hold_left = 0; m_ptr = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(negedge clk);
                if (!cv0 || acc0) begin
                    cv0 = ($urandom_range(0, 3) != 0);
                    cd0 = ($urandom_range(0, 3) == 0) ? m_ctl : rand_word();
                end
                if (!cv1 || acc1) begin
                    cv1 = ($urandom_range(0, 3) != 0);
                    cd1 = ($urandom_range(0, 3) == 0) ? m_ctl : rand_word();
                end
                drive(cv0, cv1, cd0, cd1);
                sel = -1;
                if (m_hold_left == 0) begin
                    if (cv0 && cv1) sel = m_ptr;
                    else if (cv0) sel = 0;
                    else if (cv1) sel = 1;
                end
                er0 = (sel == 0);
                er1 = (sel == 1);
                #1;
                chk_rdy($sformatf("rand%0d", cyc), er0, er1);
                @(posedge clk);
                m_upd = 1'b0;
                is_new = 1'b0;
                if (sel >= 0) begin
                    dsel = (sel == 1) ? cd1 : cd0;
                    m_ptr = 1 - sel;
`ifdef TIE_ARB_CHANGE_FILTER_EN
                    is_new = (dsel != m_ctl);
`else
                    is_new = 1'b1;
`endif
                    if (is_new) begin
                        m_ctl = dsel;
                        m_gid = (sel == 1);
                        m_upd = 1'b1;
                        m_hold_left = HOLD;
                    end
                end
                if (!is_new && m_hold_left > 0) m_hold_left--;
                acc0 = er0;
                acc1 = er1;
                #1;
                chk_out($sformatf("rand%0d", cyc), m_ctl, m_upd, m_gid, (m_hold_left > 0));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
